mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 9 +
 rtl/mem_arb_if.sv | 28 ++
 rtl/mem_arb_pick.sv | 15 +
 rtl/mem_arbiter.sv | 69 ++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and parameter defaults for the memory arbiter.
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int TIMEOUT_DEF = 15;
  typedef enum logic {IDLE, WAIT} state_t;
  typedef enum logic [1:0] {NONE, FETCH, LOAD, STORE} owner_t;
endpackage

// File: rtl/mem_arb_if.sv
// mem_arb_if: requester handshakes, response pulses and the single memory port.
interface mem_arb_if import mem_arb_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic f_valid, l_valid, s_valid;
  logic f_ready, l_ready, s_ready;
  logic [ADDR_W-1:0] f_addr, l_addr, s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic f_resp, l_resp, s_resp;
  logic [DATA_W-1:0] resp_rdata;
  logic resp_err;
  logic mem_valid, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (
    input  f_valid, l_valid, s_valid, f_addr, l_addr, s_addr, s_wdata, mem_rvalid, mem_rdata,
    output f_ready, l_ready, s_ready, f_resp, l_resp, s_resp, resp_rdata, resp_err,
           mem_valid, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output f_valid, l_valid, s_valid, f_addr, l_addr, s_addr, s_wdata, mem_rvalid, mem_rdata,
    input  f_ready, l_ready, s_ready, f_resp, l_resp, s_resp, resp_rdata, resp_err,
           mem_valid, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: store > load > fetch priority, overridden to fetch once it has starved.
module mem_arb_pick import mem_arb_pkg::*; #(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int SW = $clog2(STARVE_LIMIT + 1)
) (
  input  logic          f_valid,
  input  logic          l_valid,
  input  logic          s_valid,
  input  logic [SW-1:0] starve_cnt,
  output owner_t        win
);
  always_comb
    win = (f_valid && starve_cnt == SW'(STARVE_LIMIT)) ? FETCH :
          s_valid ? STORE : l_valid ? LOAD : f_valid ? FETCH : NONE;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants one of fetch/load/store to a single memory port, one transaction
// outstanding, with fetch anti-starvation and a response timeout.
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic      CLK,
  input logic      RESET,
  mem_arb_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state;
  owner_t owner, win;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tcnt;
  logic issue, done;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT), .SW(SW)) u_pick (
    .f_valid(bus.f_valid),
    .l_valid(bus.l_valid),
    .s_valid(bus.s_valid),
    .starve_cnt(starve_cnt),
    .win(win)
  );
  // Everything is gated by RESET so outputs read 0 during reset regardless of state.
  // A completion arriving in the expiry cycle wins over the timeout.
  always_comb begin
    issue = RESET && state == IDLE && win != NONE;
    done = RESET && state == WAIT && (bus.mem_rvalid || tcnt == TW'(TIMEOUT - 1));
    win_addr = win == STORE ? bus.s_addr : win == LOAD ? bus.l_addr : bus.f_addr;
    win_wdata = win == STORE ? bus.s_wdata : '0;
    bus.f_ready = issue && win == FETCH;
    bus.l_ready = issue && win == LOAD;
    bus.s_ready = issue && win == STORE;
    bus.mem_valid = issue;
    bus.mem_we = issue && win == STORE;
    bus.mem_addr = issue ? win_addr : '0;
    bus.mem_wdata = issue ? win_wdata : '0;
    bus.f_resp = done && owner == FETCH;
    bus.l_resp = done && owner == LOAD;
    bus.s_resp = done && owner == STORE;
    bus.resp_err = done && !bus.mem_rvalid;
    bus.resp_rdata = (done && bus.mem_rvalid && owner != STORE) ? bus.mem_rdata : '0;
  end
  always_ff @(posedge CLK)
    if (!RESET) begin
      state <= IDLE;
      owner <= NONE;
      starve_cnt <= '0;
      tcnt <= '0;
    end else if (state == IDLE) begin
      if (win != NONE) begin
        state <= WAIT;
        owner <= win;
        tcnt <= '0;
        starve_cnt <= win == FETCH ? '0 :
                      (bus.f_valid && starve_cnt != SW'(STARVE_LIMIT)) ? starve_cnt + SW'(1) : starve_cnt;
      end
    end else if (done) begin
      state <= IDLE;
      owner <= NONE;
      tcnt <= '0;
    end else
      tcnt <= tcnt + TW'(1);
endmodule
